chacha_keystream_xor: RTL

CHACHA_KEYSTREAM_XOR -- requirements
Module: chacha_keystream_xor

---
 rtl/chacha_pkg.sv | 23 ++
 rtl/ks_block_fifo.sv | 64 ++++++
 rtl/chacha_keystream_xor.sv | 82 ++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha keystream XOR datapath: word, 4x4 keystream matrix,
// block-buffer control states and the byte-keep mask helper.
package chacha_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int FIFO_DEPTH  = 2;

    typedef logic [31:0] word_t;

    // Word index i lives at [i/4][i%4] (row-major, row = i[3:2], col = i[1:0]).
    typedef word_t [3:0][3:0] ks_matrix_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    function automatic word_t keep_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

endpackage

// File: rtl/ks_block_fifo.sv
// Two-entry FIFO of keystream blocks; the EMPTY/ONE/FULL control FSM is the
// occupancy itself and is exported for observation.
module ks_block_fifo
    import chacha_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  ks_matrix_t  din,
    output ks_matrix_t  head,
    output logic [1:0]  occupancy,
    output fifo_state_t state
);

    ks_matrix_t  mem [FIFO_DEPTH];
    logic        wr_sel;
    logic        rd_sel;
    fifo_state_t state_q;
    fifo_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_sel <= ~wr_sel;
            if (pop)  rd_sel <= ~rd_sel;
        end
    end

    // Storage needs no reset: the state register alone marks entries valid.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_sel] <= din;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_d = ST_FULL;
                else if (pop && !push) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop && !push) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign state = state_q;
    assign head  = mem[rd_sel];

endmodule

// File: rtl/chacha_keystream_xor.sv
// XORs a plaintext word stream with buffered ChaCha keystream blocks, one word
// per cycle, releasing a block at its 16th word or at the end of a message.
module chacha_keystream_xor
    import chacha_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ks_valid,
    input  ks_matrix_t  ks_block,
    output logic        ks_ready,
    input  logic        pt_valid,
    input  logic [31:0] pt_data,
    input  logic [3:0]  pt_keep,
    input  logic        pt_last,
    output logic        pt_ready,
    output logic        ct_valid,
    output logic [31:0] ct_data,
    output logic [3:0]  ct_keep,
    output logic        ct_last,
    input  logic        ct_ready,
    output logic [3:0]  blocks_consumed,
    output fifo_state_t state
);

    // Handshakes: a beat moves on a rising edge where valid && ready; a source
    // holds its payload stable while valid is high and ready is low, and ready
    // never depends combinationally on the valid of the same channel.

    logic [3:0] ptr;
    logic [1:0] occupancy;
    ks_matrix_t head;
    word_t      ks_word;
    logic       ks_load;
    logic       pt_fire;
    logic       release_head;

    assign ks_ready     = (occupancy < 2'd2) && !rst;
    assign pt_ready     = (occupancy != 2'd0) && (!ct_valid || ct_ready) && !rst;
    assign ks_load      = ks_valid && ks_ready;
    assign pt_fire      = pt_valid && pt_ready;
    assign release_head = pt_fire && ((ptr == 4'(BLOCK_WORDS - 1)) || pt_last);
    assign ks_word      = head[ptr[3:2]][ptr[1:0]];

    ks_block_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ks_load),
        .pop       (release_head),
        .din       (ks_block),
        .head      (head),
        .occupancy (occupancy),
        .state     (state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr             <= '0;
            ct_valid        <= 1'b0;
            ct_data         <= '0;
            ct_keep         <= '0;
            ct_last         <= 1'b0;
            blocks_consumed <= '0;
        end else begin
            if (pt_fire) begin
                ct_data  <= (pt_data ^ ks_word) & keep_mask(pt_keep);
                ct_keep  <= pt_keep;
                ct_last  <= pt_last;
                ct_valid <= 1'b1;
            end else if (ct_ready) begin
                ct_valid <= 1'b0;
            end
            // A block ended early by pt_last drops its remaining words.
            if (release_head) begin
                ptr             <= '0;
                blocks_consumed <= blocks_consumed + 4'd1;
            end else if (pt_fire) begin
                ptr <= ptr + 4'd1;
            end
        end
    end

endmodule
